// File: rtl/prg_inject_pkg.sv
// prg_inject_pkg
// Shared types and helpers for the PRG download/inject block.
//   prg_state_t  : controller states (IDLE, HDR, DATA, PATCH, DONE)
//   C16_PTR_LIST : default table of BASIC end-of-program pointer locations
//                  (16-bit entries, entry 0 in the lowest bits)
//   ptr_at()     : extracts entry i of a packed pointer table of aw-bit entries
package prg_inject_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      PATCH,
      DONE
   } prg_state_t;

   localparam int PTR_VEC_MAX = 1024;

   localparam logic [63:0] C16_PTR_LIST = {16'h009D, 16'h0031, 16'h002F, 16'h002D};

   // The table is passed zero-padded to a fixed maximum width so one helper
   // serves every address width; the result is masked down to aw bits.
   function automatic logic [31:0] ptr_at(input logic [PTR_VEC_MAX-1:0] list,
                                          input int unsigned aw,
                                          input int unsigned i);
      return 32'(list >> (i * aw)) & ((32'd1 << aw) - 32'd1);
   endfunction

endpackage

// File: rtl/prg_hold_reg.sv
// prg_hold_reg
// One-entry skid register between the ioctl byte stream and the RAM port.
//   clk_sys   : system clock
//   reset     : synchronous, active-high
//   clear     : empties the register (download restart)
//   in_valid  : a byte is offered this cycle
//   in_data   : offered byte
//   out_ready : downstream accepts the held byte this cycle
//   out_valid : register holds a byte
//   out_data  : held byte
//   wait_req  : register full and not draining this cycle (stall the source)
//   empty     : register holds nothing
module prg_hold_reg
   import prg_inject_pkg::*;
(
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       clear,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       wait_req,
   output logic       empty
);

   logic       full;
   logic [7:0] data;
   logic       out_fire;

   assign out_fire  = full & out_ready;
   assign out_valid = full;
   assign out_data  = data;
   assign wait_req  = full & ~out_fire;
   assign empty     = ~full;

   // A new byte may enter when the register is empty or is being drained in
   // the same cycle; a byte offered while full and stalled is dropped, since
   // the source is expected to honour wait_req.
   always_ff @(posedge clk_sys) begin
      if (reset || clear) begin
         full <= 1'b0;
         data <= 8'h00;
      end else if (in_valid && (!full || out_fire)) begin
         full <= 1'b1;
         data <= in_data;
      end else if (out_fire) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/prg_inject.sv
// prg_inject
// Streams a PRG file from the HPS ioctl interface into main RAM. The first
// two file bytes form a little-endian load address, the rest is payload.
// After the payload the BASIC end-of-program pointers listed in PTR_LIST are
// patched with the first free address.
//   clk_sys, reset         : clock, synchronous active-high reset
//   ioctl_download/index   : download in progress / file index
//   ioctl_wr/addr/dout     : byte strobe, byte offset, byte data
//   ioctl_wait             : stall request back to the HPS
//   mem_addr/data/wr/ready : RAM write port, valid held until ready
//   busy                   : controller not idle
//   load_start/load_end    : load address / first free address after payload
//   done                   : one-cycle pulse when the load completes
//   error                  : sticky short-file or address-wrap flag
module prg_inject
   import prg_inject_pkg::*;
#(
   parameter int AW = 16,
   parameter int NPTR = 4,
   parameter logic [((NPTR > 0) ? NPTR * AW : 1) - 1:0] PTR_LIST = C16_PTR_LIST,
   parameter logic [7:0] PRG_INDEX = 8'd1
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ioctl_download,
   input  logic [7:0]    ioctl_index,
   input  logic          ioctl_wr,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   output logic          ioctl_wait,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_data,
   output logic          mem_wr,
   input  logic          mem_ready,
   output logic          busy,
   output logic [AW-1:0] load_start,
   output logic [AW-1:0] load_end,
   output logic          done,
   output logic          error
);

   localparam logic [AW-1:0] ADDR_MAX = '1;
   localparam int PCW = (NPTR > 1) ? $clog2(2 * NPTR) : 1;
   localparam logic [PCW-1:0] PATCH_LAST = PCW'(2 * NPTR - 1);
   localparam logic [PTR_VEC_MAX-1:0] PTR_VEC = PTR_VEC_MAX'(PTR_LIST);

   prg_state_t     state;
   prg_state_t     next_state;
   logic           active_dl;
   logic           active_q;
   logic           dl_rise;
   logic [AW-1:0]  wp;
   logic [PCW-1:0] pidx;
   logic           wr_enable;
   logic           data_fire;
   logic           wrap_hit;
   logic           hold_load;
   logic           hold_valid;
   logic           hold_empty;
   logic           hold_wait;
   logic [7:0]     hold_data;
   logic [AW-1:0]  hdr_addr;
   logic [AW-1:0]  patch_addr;
   logic [7:0]     patch_data;

   // Only downloads of our own file index exist as far as this block is
   // concerned. A rising edge restarts the load from any state, so payload
   // writes are suppressed in that cycle to avoid a stray RAM write.
   assign active_dl = ioctl_download & (ioctl_index == PRG_INDEX);
   assign dl_rise   = active_dl & ~active_q;
   assign wr_enable = (state == DATA) & ~error & ~dl_rise;
   assign data_fire = hold_valid & wr_enable & mem_ready;
   assign wrap_hit  = data_fire & (wp == ADDR_MAX);

   // Bytes are refused once the address space is exhausted, including a byte
   // arriving in the very cycle the last address is written; this keeps the
   // holding register empty so ioctl_wait cannot stick high after a wrap.
   assign hold_load = (state == DATA) & active_dl & ioctl_wr & ~error & ~wrap_hit;

   // The header address is always 16 bits in the file; it is truncated or
   // zero-extended to the RAM address width.
   assign hdr_addr = AW'({ioctl_dout, load_start[7:0]});

   // Patch writes alternate low byte / high byte for each table entry.
   assign patch_addr = AW'(ptr_at(PTR_VEC, AW, 32'(pidx >> 1))) + AW'(pidx[0]);
   assign patch_data = pidx[0] ? 8'(load_end >> 8) : load_end[7:0];

   assign ioctl_wait = hold_wait;
   assign busy       = (state != IDLE);

   prg_hold_reg u_hold (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .clear     (dl_rise),
      .in_valid  (hold_load),
      .in_data   (ioctl_dout),
      .out_ready (wr_enable & mem_ready),
      .out_valid (hold_valid),
      .out_data  (hold_data),
      .wait_req  (hold_wait),
      .empty     (hold_empty)
   );

   // State register.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and RAM port control. The payload must be fully drained before
   // the download end is acted on; a wrapped load skips the pointer patch but
   // still reports completion.
   always_comb begin
      next_state = state;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_data   = 8'h00;
      done       = 1'b0;
      case (state)
         IDLE: begin
         end
         HDR: begin
            if (!active_dl) begin
               next_state = IDLE;
            end else if (ioctl_wr && (ioctl_addr == 25'd1)) begin
               next_state = DATA;
            end
         end
         DATA: begin
            mem_wr   = hold_valid & wr_enable;
            mem_addr = wp;
            mem_data = hold_data;
            if (!active_dl && hold_empty) begin
               next_state = (error || (NPTR == 0)) ? DONE : PATCH;
            end
         end
         PATCH: begin
            mem_wr   = ~dl_rise;
            mem_addr = patch_addr;
            mem_data = patch_data;
            if (mem_ready && (pidx == PATCH_LAST)) begin
               next_state = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      if (dl_rise) begin
         next_state = HDR;
      end
   end

   // Datapath: header capture, write pointer, load_end tracking, error flag
   // and patch index. At the top of the address space load_end stays frozen
   // at the last address instead of wrapping to zero.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         active_q   <= 1'b0;
         error      <= 1'b0;
         load_start <= '0;
         load_end   <= '0;
         wp         <= '0;
         pidx       <= '0;
      end else begin
         active_q <= active_dl;

         if (dl_rise) begin
            error <= 1'b0;
         end else if ((state == HDR) && !active_dl) begin
            error <= 1'b1;
         end else if (wrap_hit) begin
            error <= 1'b1;
         end

         if ((state == HDR) && active_dl && ioctl_wr && !dl_rise) begin
            if (ioctl_addr == 25'd0) begin
               load_start[7:0] <= ioctl_dout;
            end else if (ioctl_addr == 25'd1) begin
               load_start <= hdr_addr;
               load_end   <= hdr_addr;
               wp         <= hdr_addr;
            end
         end

         if (data_fire && !wrap_hit) begin
            wp       <= wp + 1'b1;
            load_end <= wp + 1'b1;
         end

         if (state != PATCH) begin
            pidx <= '0;
         end else if (mem_ready && !dl_rise) begin
            pidx <= pidx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_prg_inject.sv
// tb_prg_inject
// Self-checking bench for prg_inject: an HPS byte-stream driver that honours
// ioctl_wait, a RAM responder with optional backpressure that logs accepted
// writes, and a reference model that derives the expected write list, load
// addresses and status from the file contents.
module tb_prg_inject;

   logic        clk_sys;
   logic        reset;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_wr;
   logic        mem_ready;
   logic        busy;
   logic [15:0] load_start;
   logic [15:0] load_end;
   logic        done;
   logic        error;

   int          checks;
   int          fails;
   logic [23:0] got_q[$];
   int          done_cnt;
   int          wait_hi;
   int          stall_cnt;
   bit          bp_mode;
   logic [7:0]  stim[$];

   prg_inject #(
      .AW        (16),
      .NPTR      (4),
      .PRG_INDEX (8'd1)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .mem_wr         (mem_wr),
      .mem_ready      (mem_ready),
      .busy           (busy),
      .load_start     (load_start),
      .load_end       (load_end),
      .done           (done),
      .error          (error)
   );

   // 100 MHz clock.
   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   // Hard time limit so a hung design still ends the run.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: observed no completion, expected end of test");
      $fatal(1, "[TB] time limit reached");
   end

   // RAM responder: ready is chosen at the falling edge, the handshake is
   // sampled 2 ns later and logged. In backpressure mode every write is held
   // off for five cycles before it is accepted.
   initial begin
      mem_ready = 1'b1;
      stall_cnt = 0;
      done_cnt  = 0;
      wait_hi   = 0;
      forever begin
         @(negedge clk_sys);
         mem_ready = bp_mode ? (stall_cnt >= 5) : 1'b1;
         #2;
         if (mem_wr && mem_ready) begin
            got_q.push_back({mem_addr, mem_data});
            stall_cnt = 0;
         end else if (mem_wr) begin
            stall_cnt++;
         end else begin
            stall_cnt = 0;
         end
         if (done) done_cnt++;
         if (ioctl_wait) wait_hi++;
      end
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic startDownload(input logic [7:0] idx);
      @(negedge clk_sys);
      #1;
      ioctl_download = 1'b1;
      ioctl_index    = idx;
   endtask

   task automatic endDownload();
      ioctl_download = 1'b0;
   endtask

   // HPS model: one byte per strobe, never offered while ioctl_wait is high,
   // with random idle gaps between bytes.
   task automatic sendBytes(input logic [7:0] q[$]);
      @(negedge clk_sys);
      #1;
      for (int k = 0; k < q.size(); k++) begin
         int guard = 0;
         while (ioctl_wait && guard < 100) begin
            @(negedge clk_sys);
            #1;
            guard++;
         end
         if (guard >= 100) checkOutput("wait_bound", 32'(ioctl_wait), 32'd0);
         ioctl_wr   = 1'b1;
         ioctl_addr = 25'(k);
         ioctl_dout = q[k];
         @(negedge clk_sys);
         #1;
         ioctl_wr = 1'b0;
         repeat ($urandom_range(0, 1)) begin
            @(negedge clk_sys);
            #1;
         end
      end
   endtask

   task automatic waitIdle(input string tag);
      int guard = 0;
      while (busy && guard < 600) begin
         @(negedge clk_sys);
         #1;
         guard++;
      end
      if (busy) checkOutput({tag, "_idle_bound"}, 32'(busy), 32'd0);
      @(negedge clk_sys);
      #1;
   endtask

   // Runs one complete file download and waits for the block to settle.
   task automatic applyStimulus(input logic [7:0] q[$], input logic [7:0] idx);
      got_q.delete();
      done_cnt = 0;
      startDownload(idx);
      sendBytes(q);
      if (idx != 8'd1) begin
         checkOutput("wrongidx_busy_mid", 32'(busy), 32'd0);
         checkOutput("wrongidx_wait_mid", 32'(ioctl_wait), 32'd0);
      end
      endDownload();
      waitIdle("file");
   endtask

   // Reference model: payload goes to consecutive addresses from the load
   // address until the last address has been written; touching the last
   // address is an error and suppresses the pointer patch.
   task automatic checkResult(input logic [7:0] q[$], input string name);
      logic [23:0] exp_q[$];
      int ptrs[4] = '{'h2D, 'h2F, 'h31, 'h9D};
      int ls;
      int pay;
      int le;
      int nfit;
      bit err;
      int n;
      if (q.size() < 2) begin
         checkOutput({name, "_error"}, 32'(error), 32'd1);
         checkOutput({name, "_nwrites"}, 32'(got_q.size()), 32'd0);
         checkOutput({name, "_done"}, 32'(done_cnt), 32'd0);
         checkOutput({name, "_busy"}, 32'(busy), 32'd0);
         return;
      end
      ls   = int'(q[0]) + 256 * int'(q[1]);
      pay  = q.size() - 2;
      err  = (ls + pay) > 'hFFFF;
      nfit = err ? ('h10000 - ls) : pay;
      le   = err ? 'hFFFF : ls + pay;
      for (int k = 0; k < nfit; k++) exp_q.push_back({16'(ls + k), q[k + 2]});
      if (!err) begin
         for (int i = 0; i < 4; i++) begin
            exp_q.push_back({16'(ptrs[i]), 8'(le)});
            exp_q.push_back({16'(ptrs[i] + 1), 8'(le >> 8)});
         end
      end
      checkOutput({name, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s_wr%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
      end
      checkOutput({name, "_load_start"}, 32'(load_start), 32'(ls));
      checkOutput({name, "_load_end"}, 32'(load_end), 32'(le));
      checkOutput({name, "_error"}, 32'(error), 32'(err));
      checkOutput({name, "_done"}, 32'(done_cnt), 32'd1);
      checkOutput({name, "_busy"}, 32'(busy), 32'd0);
      checkOutput({name, "_wait"}, 32'(ioctl_wait), 32'd0);
   endtask

   // Expects every output at its reset value.
   task automatic checkResetState(input string name);
      checkOutput({name, "_mem_wr"}, 32'(mem_wr), 32'd0);
      checkOutput({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
      checkOutput({name, "_mem_data"}, 32'(mem_data), 32'd0);
      checkOutput({name, "_wait"}, 32'(ioctl_wait), 32'd0);
      checkOutput({name, "_busy"}, 32'(busy), 32'd0);
      checkOutput({name, "_load_start"}, 32'(load_start), 32'd0);
      checkOutput({name, "_load_end"}, 32'(load_end), 32'd0);
      checkOutput({name, "_done"}, 32'(done), 32'd0);
      checkOutput({name, "_error"}, 32'(error), 32'd0);
   endtask

   // Directed scenarios first, then randomized files with random backpressure.
   initial begin
      int guard;
      checks         = 0;
      fails          = 0;
      bp_mode        = 1'b0;
      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_index    = 8'd0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = 8'h00;
      repeat (3) @(negedge clk_sys);
      #1;
      checkResetState("reset");
      reset = 1'b0;

      $display("[TB] basic load");
      stim = '{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC};
      applyStimulus(stim, 8'd1);
      checkResult(stim, "basic");

      $display("[TB] backpressure");
      bp_mode = 1'b1;
      wait_hi = 0;
      applyStimulus(stim, 8'd1);
      checkResult(stim, "bp");
      checkOutput("bp_wait_seen", 32'(wait_hi != 0), 32'd1);
      bp_mode = 1'b0;

      $display("[TB] wrap");
      stim = '{8'hFE, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
      applyStimulus(stim, 8'd1);
      checkResult(stim, "wrap");

      $display("[TB] zero payload");
      stim = '{8'h00, 8'h08};
      applyStimulus(stim, 8'd1);
      checkResult(stim, "empty");

      $display("[TB] short file");
      stim = '{8'h34};
      applyStimulus(stim, 8'd1);
      checkResult(stim, "short");

      $display("[TB] wrong index");
      stim = '{8'h00, 8'h30, 8'h01, 8'h02};
      applyStimulus(stim, 8'd2);
      checkOutput("wrongidx_nwrites", 32'(got_q.size()), 32'd0);
      checkOutput("wrongidx_busy", 32'(busy), 32'd0);
      checkOutput("wrongidx_wait", 32'(ioctl_wait), 32'd0);
      checkOutput("wrongidx_done", 32'(done_cnt), 32'd0);

      $display("[TB] abort during patch");
      stim = '{8'h00, 8'h40, 8'h5A, 8'h5B, 8'h5C};
      got_q.delete();
      done_cnt = 0;
      startDownload(8'd1);
      sendBytes(stim);
      endDownload();
      guard = 0;
      while (got_q.size() < 5 && guard < 200) begin
         @(negedge clk_sys);
         #1;
         guard++;
      end
      checkOutput("abort_reached_patch", 32'(got_q.size()), 32'd5);
      ioctl_download = 1'b1;
      got_q.delete();
      done_cnt = 0;
      #1;
      checkOutput("abort_mem_wr_drop", 32'(mem_wr), 32'd0);
      @(negedge clk_sys);
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd1);
      checkOutput("abort_mem_wr_hdr", 32'(mem_wr), 32'd0);
      stim = '{8'h80, 8'h21, 8'hE1, 8'hE2};
      sendBytes(stim);
      endDownload();
      waitIdle("abort");
      checkResult(stim, "abort");

      $display("[TB] reset mid-data");
      bp_mode = 1'b1;
      got_q.delete();
      startDownload(8'd1);
      sendBytes('{8'h00, 8'h20, 8'h01, 8'h02, 8'h03});
      checkOutput("rst_busy_pre", 32'(busy), 32'd1);
      reset          = 1'b1;
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      #1;
      checkResetState("rst_mid");
      reset   = 1'b0;
      bp_mode = 1'b0;
      stim = '{8'h10, 8'h30, 8'h77, 8'h88};
      applyStimulus(stim, 8'd1);
      checkResult(stim, "after_rst");

      $display("[TB] random files");
      for (int t = 0; t < 16; t++) begin
         logic [15:0] ls;
         int          n;
         stim.delete();
         if ($urandom_range(0, 3) == 0) ls = 16'(16'hFFF6 + $urandom_range(0, 9));
         else ls = 16'($urandom);
         n = $urandom_range(0, 10);
         stim.push_back(ls[7:0]);
         stim.push_back(ls[15:8]);
         for (int k = 0; k < n; k++) stim.push_back(8'($urandom));
         bp_mode = 1'($urandom_range(0, 1));
         applyStimulus(stim, 8'd1);
         checkResult(stim, $sformatf("rand%0d", t));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
